// File: rtl/skinny_sbox_layer_sched_d2.sv
// Nibble-serial sequencer for a 3-share masked Skinny S-box over a 64-bit shared state.
// Optional build macro SKINNY_SBOX_SCHED_ZEROIZE_EN clears operand/randomness/working registers when not in use.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready, waiting for start
// FETCH | waiting on PRNG; latch fresh bits and operand nibble idx
// SRST  | one-cycle S-box controller reset, eval counter cleared
// EVAL  | operand held, wait for sbox_Synch or timeout
// STORE | write captured S-box result into nibble idx
// DONE  | one-cycle done pulse
// ERR   | sticky timeout, left only through rst
module skinny_sbox_layer_sched_d2 #(
   parameter int NIBBLES = 16,
   parameter int FRESH_W = 51,
   parameter int LATENCY = 9,
   parameter int TIMEOUT = LATENCY + 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 ready,
   output logic                 done,
   output logic                 error,
   input  logic [4*NIBBLES-1:0] state_in_s0,
   input  logic [4*NIBBLES-1:0] state_in_s1,
   input  logic [4*NIBBLES-1:0] state_in_s2,
   output logic [4*NIBBLES-1:0] state_out_s0,
   output logic [4*NIBBLES-1:0] state_out_s1,
   output logic [4*NIBBLES-1:0] state_out_s2,
   input  logic [FRESH_W-1:0]   rnd_in,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   output logic [3:0]           sbox_X_s0,
   output logic [3:0]           sbox_X_s1,
   output logic [3:0]           sbox_X_s2,
   output logic [FRESH_W-1:0]   sbox_Fresh,
   output logic                 sbox_rst,
   input  logic [3:0]           sbox_Y_s0,
   input  logic [3:0]           sbox_Y_s1,
   input  logic [3:0]           sbox_Y_s2,
   input  logic                 sbox_Synch
);
   localparam int SW = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SRST, S_EVAL, S_STORE, S_DONE, S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SW-1:0]      work_s0_q, work_s0_d;
   logic [SW-1:0]      work_s1_q, work_s1_d;
   logic [SW-1:0]      work_s2_q, work_s2_d;
   logic [3:0]         x_s0_q, x_s0_d;
   logic [3:0]         x_s1_q, x_s1_d;
   logic [3:0]         x_s2_q, x_s2_d;
   logic [3:0]         y_s0_q, y_s0_d;
   logic [3:0]         y_s1_q, y_s1_d;
   logic [3:0]         y_s2_q, y_s2_d;
   logic [FRESH_W-1:0] fresh_q, fresh_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         work_s0_q <= '0;
         work_s1_q <= '0;
         work_s2_q <= '0;
         x_s0_q    <= '0;
         x_s1_q    <= '0;
         x_s2_q    <= '0;
         y_s0_q    <= '0;
         y_s1_q    <= '0;
         y_s2_q    <= '0;
         fresh_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         work_s0_q <= work_s0_d;
         work_s1_q <= work_s1_d;
         work_s2_q <= work_s2_d;
         x_s0_q    <= x_s0_d;
         x_s1_q    <= x_s1_d;
         x_s2_q    <= x_s2_d;
         y_s0_q    <= y_s0_d;
         y_s1_q    <= y_s1_d;
         y_s2_q    <= y_s2_d;
         fresh_q   <= fresh_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      work_s0_d = work_s0_q;
      work_s1_d = work_s1_q;
      work_s2_d = work_s2_q;
      x_s0_d    = x_s0_q;
      x_s1_d    = x_s1_q;
      x_s2_d    = x_s2_q;
      y_s0_d    = y_s0_q;
      y_s1_d    = y_s1_q;
      y_s2_d    = y_s2_q;
      fresh_d   = fresh_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               work_s0_d = state_in_s0;
               work_s1_d = state_in_s1;
               work_s2_d = state_in_s2;
               idx_d     = '0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (rnd_valid) begin
               fresh_d = rnd_in;
               x_s0_d  = work_s0_q[{idx_q, 2'b00} +: 4];
               x_s1_d  = work_s1_q[{idx_q, 2'b00} +: 4];
               x_s2_d  = work_s2_q[{idx_q, 2'b00} +: 4];
               state_d = S_SRST;
            end
         end
         S_SRST: begin
            cnt_d   = '0;
            state_d = S_EVAL;
         end
         S_EVAL: begin
            cnt_d = cnt_q + CW'(1);
            // A Synch arriving on the timeout cycle still counts as a result.
            if (sbox_Synch) begin
               y_s0_d  = sbox_Y_s0;
               y_s1_d  = sbox_Y_s1;
               y_s2_d  = sbox_Y_s2;
               state_d = S_STORE;
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
               x_s0_d  = '0;
               x_s1_d  = '0;
               x_s2_d  = '0;
               fresh_d = '0;
`endif
            end else if (cnt_d == CW'(TIMEOUT)) begin
               state_d = S_ERR;
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
               x_s0_d    = '0;
               x_s1_d    = '0;
               x_s2_d    = '0;
               fresh_d   = '0;
               work_s0_d = '0;
               work_s1_d = '0;
               work_s2_d = '0;
`endif
            end
         end
         S_STORE: begin
            work_s0_d[{idx_q, 2'b00} +: 4] = y_s0_q;
            work_s1_d[{idx_q, 2'b00} +: 4] = y_s1_q;
            work_s2_d[{idx_q, 2'b00} +: 4] = y_s2_q;
            if (idx_q == IW'(NIBBLES - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are masked by rst so nothing is offered or consumed during reset.
   assign ready        = (state_q == S_IDLE) && !rst;
   assign rnd_ready    = (state_q == S_FETCH) && !rst;
   assign done         = (state_q == S_DONE) && !rst;
   assign error        = (state_q == S_ERR);
   assign sbox_rst     = rst || (state_q == S_SRST);
   assign state_out_s0 = work_s0_q;
   assign state_out_s1 = work_s1_q;
   assign state_out_s2 = work_s2_q;
   assign sbox_X_s0    = x_s0_q;
   assign sbox_X_s1    = x_s1_q;
   assign sbox_X_s2    = x_s2_q;
   assign sbox_Fresh   = fresh_q;

endmodule

// File: tb/tb_skinny_sbox_layer_sched_d2.sv
// Self-checking bench for skinny_sbox_layer_sched_d2 with a behavioural masked S-box and layer model.
module tb_skinny_sbox_layer_sched_d2;
   localparam int NIB = 16;
   localparam int FW  = 51;

   logic          clk = 1'b0;
   logic          rst, start, ready, done, error;
   logic [63:0]   state_in_s0, state_in_s1, state_in_s2;
   logic [63:0]   state_out_s0, state_out_s1, state_out_s2;
   logic [FW-1:0] rnd_in, sbox_Fresh;
   logic          rnd_valid, rnd_ready, sbox_rst, sbox_Synch;
   logic [3:0]    sbox_X_s0, sbox_X_s1, sbox_X_s2;
   logic [3:0]    sbox_Y_s0, sbox_Y_s1, sbox_Y_s2;

   always #5 clk = ~clk;

   skinny_sbox_layer_sched_d2 dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done), .error(error),
      .state_in_s0(state_in_s0), .state_in_s1(state_in_s1), .state_in_s2(state_in_s2),
      .state_out_s0(state_out_s0), .state_out_s1(state_out_s1), .state_out_s2(state_out_s2),
      .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .sbox_X_s0(sbox_X_s0), .sbox_X_s1(sbox_X_s1), .sbox_X_s2(sbox_X_s2),
      .sbox_Fresh(sbox_Fresh), .sbox_rst(sbox_rst),
      .sbox_Y_s0(sbox_Y_s0), .sbox_Y_s1(sbox_Y_s1), .sbox_Y_s2(sbox_Y_s2),
      .sbox_Synch(sbox_Synch)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] sbox4(input logic [3:0] v);
      case (v)
         4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
         4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
         4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
         4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
      endcase
   endfunction

   function automatic logic [63:0] subcells(input logic [63:0] p);
      logic [63:0] r = '0;
      for (int i = 0; i < NIB; i++) r[i*4 +: 4] = sbox4(p[i*4 +: 4]);
      return r;
   endfunction

   // Masked S-box model: fresh masks per evaluation, Synch synch_at cycles after sbox_rst drops.
   logic [3:0] sb_cnt = 4'h0;
   logic [3:0] m1 = 4'h0, m2 = 4'h0;
   int         synch_at = 8;
   logic       withhold = 1'b0;

   always @(posedge clk) begin
      if (sbox_rst) begin
         sb_cnt <= 4'h0;
         m1     <= 4'($urandom);
         m2     <= 4'($urandom);
      end else if (sb_cnt != 4'hF) begin
         sb_cnt <= sb_cnt + 4'h1;
      end
   end

   assign sbox_Synch = !sbox_rst && !withhold && (int'(sb_cnt) == synch_at);
   assign sbox_Y_s1  = m1;
   assign sbox_Y_s2  = m2;
   assign sbox_Y_s0  = sbox4(sbox_X_s0 ^ sbox_X_s1 ^ sbox_X_s2) ^ m1 ^ m2;

   typedef struct {
      logic [3:0]    x0, x1, x2, m1, m2;
      logic [FW-1:0] fr;
   } ev_t;

   ev_t           evq[$];
   logic [FW-1:0] hsq[$];
   logic [63:0]   s0, s1, s2;
   logic [3:0]    hx0 = 4'h0, hx1 = 4'h0, hx2 = 4'h0;
   logic [FW-1:0] hfr = '0;
   int            done_cyc, err_cyc, hold_bad, stall_drop;

   task automatic do_reset(input string nm);
      rst = 1'b1;
      start = 1'b1;
      rnd_valid = 1'b1;
      @(posedge clk); #1;
      chk({nm, " ready_in_rst"}, 128'(ready), 128'(0));
      chk({nm, " done_in_rst"}, 128'(done), 128'(0));
      chk({nm, " error_in_rst"}, 128'(error), 128'(0));
      chk({nm, " rnd_ready_in_rst"}, 128'(rnd_ready), 128'(0));
      chk({nm, " sbox_rst_in_rst"}, 128'(sbox_rst), 128'(1));
      chk({nm, " state_out_in_rst"}, {state_out_s0, state_out_s1}, 128'(0));
      chk({nm, " state_out_s2_in_rst"}, 128'(state_out_s2), 128'(0));
      chk({nm, " x_fresh_in_rst"}, {sbox_X_s0, sbox_X_s1, sbox_X_s2, sbox_Fresh}, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk({nm, " ready_after_rst"}, 128'(ready), 128'(1));
      chk({nm, " start_during_rst_ignored"}, 128'(rnd_ready), 128'(0));
      chk({nm, " sbox_rst_after_rst"}, 128'(sbox_rst), 128'(0));
      hx0 = 4'h0; hx1 = 4'h0; hx2 = 4'h0; hfr = '0;
   endtask

   // Runs one layer until done, error, abort_cyc or the cycle budget; cycle 1 follows the start edge.
   task automatic run(input logic [63:0] plain, input int stall_len, input int pulse_cyc,
                      input int wh_nib, input int abort_cyc);
      int cyc, stalled;
      bit store_next;
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      s0 = s1 ^ s2 ^ plain;
      state_in_s0 = s0; state_in_s1 = s1; state_in_s2 = s2;
      start = 1'b1;
      rnd_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; stalled = 0; store_next = 0;
      done_cyc = 0; err_cyc = 0; hold_bad = 0; stall_drop = 0;
      evq.delete(); hsq.delete();
      while (cyc < 400) begin
         if (done) begin done_cyc = cyc; break; end
         if (error) begin err_cyc = cyc; break; end
         if (cyc == abort_cyc) break;
         withhold = (evq.size() == wh_nib);
         rnd_in = FW'({$urandom, $urandom});
         if (hsq.size() == 3 && stalled < stall_len && (stalled > 0 || rnd_ready)) begin
            if (!rnd_ready) stall_drop++;
            rnd_valid = 1'b0;
            stalled++;
         end else begin
            rnd_valid = 1'b1;
         end
         if (rnd_ready || store_next) begin
`ifdef SKINNY_SBOX_SCHED_ZEROIZE_EN
            if ({sbox_X_s0, sbox_X_s1, sbox_X_s2} != 12'h0 || sbox_Fresh != '0) hold_bad++;
`else
            if ({sbox_X_s0, sbox_X_s1, sbox_X_s2} != {hx0, hx1, hx2} || sbox_Fresh != hfr) hold_bad++;
`endif
         end
         store_next = 0;
         if (rnd_ready && rnd_valid) hsq.push_back(rnd_in);
         if (sbox_Synch) begin
            evq.push_back('{x0: sbox_X_s0, x1: sbox_X_s1, x2: sbox_X_s2, m1: m1, m2: m2, fr: sbox_Fresh});
            hx0 = sbox_X_s0; hx1 = sbox_X_s1; hx2 = sbox_X_s2; hfr = sbox_Fresh;
            store_next = 1;
         end
         start = (cyc == pulse_cyc);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      withhold = 1'b0;
   endtask

   task automatic check_layer(input string nm, input logic [63:0] exp_sub, input int exp_cyc);
      logic [63:0] e0, e1, e2;
      e0 = '0; e1 = '0; e2 = '0;
      chk({nm, " done_cycle"}, 128'(done_cyc), 128'(exp_cyc));
      chk({nm, " eval_count"}, 128'(evq.size()), 128'(NIB));
      chk({nm, " rnd_handshakes"}, 128'(hsq.size()), 128'(NIB));
      chk({nm, " x_fresh_hold"}, 128'(hold_bad), 128'(0));
      chk({nm, " rnd_ready_through_stall"}, 128'(stall_drop), 128'(0));
      if (evq.size() == NIB && hsq.size() == NIB) begin
         for (int i = 0; i < NIB; i++) begin
            chk($sformatf("%s nib%0d operand_fresh", nm, i),
                {evq[i].x0, evq[i].x1, evq[i].x2, evq[i].fr},
                {s0[i*4 +: 4], s1[i*4 +: 4], s2[i*4 +: 4], hsq[i]});
            e1[i*4 +: 4] = evq[i].m1;
            e2[i*4 +: 4] = evq[i].m2;
            e0[i*4 +: 4] = exp_sub[i*4 +: 4] ^ evq[i].m1 ^ evq[i].m2;
         end
      end
      chk({nm, " out_s0"}, 128'(state_out_s0), 128'(e0));
      chk({nm, " out_s1"}, 128'(state_out_s1), 128'(e1));
      chk({nm, " out_s2"}, 128'(state_out_s2), 128'(e2));
      chk({nm, " out_xor"}, 128'(state_out_s0 ^ state_out_s1 ^ state_out_s2), 128'(exp_sub));
      repeat (3) begin @(posedge clk); #1; end
      chk({nm, " out_held_after_done"}, {state_out_s0 ^ e0, state_out_s1 ^ e1}, 128'(0));
      chk({nm, " ready_after_done"}, {ready, done, rnd_ready}, {1'b1, 1'b0, 1'b0});
   endtask

   typedef struct {
      logic [63:0] plain;
      int          stall;
      int          pulse;
      int          synch_at;
      logic [63:0] exp_sub;
      int          exp_cyc;
   } vec_t;

   vec_t        tbl[5];
   logic [63:0] rp;
   logic [63:0] p0, p1, p2;
   int          bad;

   initial begin
      rp = {$urandom, $urandom};
      // Stall row: 192 + 5 stall cycles of processing, done the cycle after.
      tbl[0] = '{64'h0123456789ABCDEF, 0, 0, 8, 64'hC6901A2B385D4E7F, 193};
      tbl[1] = '{64'h0123456789ABCDEF, 5, 0, 8, 64'hC6901A2B385D4E7F, 198};
      tbl[2] = '{64'h0123456789ABCDEF, 0, 50, 8, 64'hC6901A2B385D4E7F, 193};
      tbl[3] = '{rp, 0, 0, 3, subcells(rp), 113};
      tbl[4] = '{64'hFFFF0000A5A55A5A, 0, 0, 8, 64'hFFFFCCCC5A5AA5A5, 193};

      rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_in = '0;
      state_in_s0 = '0; state_in_s1 = '0; state_in_s2 = '0;
      do_reset("init");

      for (int i = 0; i < 5; i++) begin
         synch_at = tbl[i].synch_at;
         run(tbl[i].plain, tbl[i].stall, tbl[i].pulse, -1, 0);
         check_layer($sformatf("vec%0d", i), tbl[i].exp_sub, tbl[i].exp_cyc);
      end
      synch_at = 8;

      // Synch withheld on nibble 7: 13 EVAL cycles (87..99), error from cycle 100.
      run(64'h0123456789ABCDEF, 0, 0, 7, 0);
      chk("timeout err_cycle", 128'(err_cyc), 128'(100));
      chk("timeout evals_before", 128'(evq.size()), 128'(7));
      p0 = s0; p1 = s1; p2 = s2;
`ifndef SKINNY_SBOX_SCHED_ZEROIZE_EN
      for (int i = 0; i < 7 && i < evq.size(); i++) begin
         p1[i*4 +: 4] = evq[i].m1;
         p2[i*4 +: 4] = evq[i].m2;
         p0[i*4 +: 4] = sbox4(s0[i*4 +: 4] ^ s1[i*4 +: 4] ^ s2[i*4 +: 4]) ^ evq[i].m1 ^ evq[i].m2;
      end
`else
      p0 = '0; p1 = '0; p2 = '0;
`endif
      bad = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (!error || ready || done || rnd_ready) bad++;
      end
      chk("timeout sticky_err", 128'(bad), 128'(0));
      chk("timeout state_kept", {state_out_s0 ^ p0, state_out_s1 ^ p1}, 128'(0));
      chk("timeout state_kept_s2", 128'(state_out_s2), 128'(p2));
      do_reset("after_err");

      // Abort in EVAL of nibble 10 (cycles 123..131), then a clean run.
      run(64'h0F1E2D3C4B5A6978, 0, 0, -1, 127);
      chk("abort evals_before", 128'(evq.size()), 128'(10));
      do_reset("abort");
      rp = {$urandom, $urandom};
      run(rp, 0, 0, -1, 0);
      check_layer("after_abort", subcells(rp), 193);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
